// File: rtl/rv_decode_stage_pkg.sv
// rv_pkg: shared definitions for the RV32I decode stage and its helpers.
//   - opcode constants for every base-ISA major opcode the decoder accepts
//   - format class encoding (fmt_t) and funct7 constants
//   - decode_t: the bundle registered by the decode stage
//   - opcode_fmt(): maps a 7-bit opcode to its format class
package rv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef logic [2:0] fmt_t;

    localparam fmt_t FMT_R    = 3'd0;
    localparam fmt_t FMT_I    = 3'd1;
    localparam fmt_t FMT_S    = 3'd2;
    localparam fmt_t FMT_B    = 3'd3;
    localparam fmt_t FMT_U    = 3'd4;
    localparam fmt_t FMT_J    = 3'd5;
    localparam fmt_t FMT_NONE = 3'd7;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] imm;
        fmt_t        fmt;
        logic        rd_valid;
        logic        rs1_valid;
        logic        rs2_valid;
        logic        func3_valid;
        logic        func7_valid;
        logic        imm_valid;
        logic        is_m;
        logic        illegal;
    } decode_t;

    localparam decode_t DECODE_RESET = '{
        rs1: 5'd0, rs2: 5'd0, rd: 5'd0, func3: 3'd0, func7: 7'd0, imm: 32'd0,
        fmt: FMT_NONE, rd_valid: 1'b0, rs1_valid: 1'b0, rs2_valid: 1'b0,
        func3_valid: 1'b0, func7_valid: 1'b0, imm_valid: 1'b0, is_m: 1'b0,
        illegal: 1'b0
    };

    function automatic fmt_t opcode_fmt(input logic [6:0] opcode);
        case (opcode)
            OPC_OP:                       return FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: return FMT_I;
            OPC_STORE:                    return FMT_S;
            OPC_BRANCH:                   return FMT_B;
            OPC_LUI, OPC_AUIPC:           return FMT_U;
            OPC_JAL:                      return FMT_J;
            default:                      return FMT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rv_decode_stage_if.sv
// rv_decode_stage_if: fetch-side input channel plus decoded-bundle output
// channel of the decode stage.
//   master: the surroundings (fetch drives in_valid/instr/in_pc, execute
//           drives out_ready) and observes everything else
//   slave:  the decode stage itself
// Input channel:  in_valid, in_ready, instr[31:0], in_pc[PC_W-1:0]
// Output channel: out_valid, out_ready, out_pc, rs1, rs2, rd, func3, func7,
//                 imm, fmt, per-field valid flags, is_m, illegal
interface rv_decode_stage_if
    import rv_pkg::*;
#(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [31:0]     imm;
    fmt_t            fmt;
    logic            rd_valid;
    logic            rs1_valid;
    logic            rs2_valid;
    logic            func3_valid;
    logic            func7_valid;
    logic            imm_valid;
    logic            is_m;
    logic            illegal;

    modport master (
        output in_valid, instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, func3, func7, imm,
               fmt, rd_valid, rs1_valid, rs2_valid, func3_valid, func7_valid,
               imm_valid, is_m, illegal
    );

    modport slave (
        input  in_valid, instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, func3, func7, imm,
               fmt, rd_valid, rs1_valid, rs2_valid, func3_valid, func7_valid,
               imm_valid, is_m, illegal
    );

endinterface

// File: rtl/rv_decode_stage_imm_gen.sv
// rv_imm_gen: combinational immediate generator for the base RV32 formats.
// Ports:
//   instr [31:0] in  - instruction word
//   fmt   [2:0]  in  - format class from rv_pkg
//   imm   [31:0] out - sign-extended immediate, 0 for R and NONE
module rv_imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] instr,
    input  fmt_t        fmt,
    output logic [31:0] imm
);

    // The opcode bits never contribute to an immediate.
    logic [6:0] unused_opcode_bits;
    assign unused_opcode_bits = instr[6:0];

    always_comb begin
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I decode stage with valid/ready flow
// control, flush and legality checking (optionally RV32E and M extension).
// Ports:
//   clk   in  - clock, rising edge
//   rst   in  - synchronous active-high reset
//   flush in  - drop held bundle and any simultaneous incoming instruction
//   bus       - rv_decode_stage_if.slave: instruction in, decoded bundle out
// Parameters:
//   PC_W     - PC width
//   ENABLE_E - register indices >= 16 are illegal
//   ENABLE_M - funct7=0000001 on OP is a legal MUL/DIV
//   RESET_PC - out_pc value after reset until the first transfer
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter bit              ENABLE_E = 1'b0,
    parameter bit              ENABLE_M = 1'b0,
    parameter logic [PC_W-1:0] RESET_PC = '0
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    rv_decode_stage_if.slave bus
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    fmt_t            dec_fmt;
    logic [31:0]     gen_imm;
    decode_t         dec;
    decode_t         held;
    logic [PC_W-1:0] pc_q;
    logic            out_valid_q;
    logic            in_ready;
    logic            use_rd, use_rs1, use_rs2, use_f3, use_f7, use_imm;
    logic            bad;

    assign opcode  = bus.instr[6:0];
    assign f3      = bus.instr[14:12];
    assign f7      = bus.instr[31:25];
    assign dec_fmt = opcode_fmt(opcode);

    rv_imm_gen u_imm_gen (
        .instr (bus.instr),
        .fmt   (dec_fmt),
        .imm   (gen_imm)
    );

    // Which fields carry meaning for each format.
    always_comb begin
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_f3  = 1'b0;
        use_f7  = 1'b0;
        use_imm = 1'b0;
        case (dec_fmt)
            FMT_R: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                use_f3 = 1'b1; use_f7 = 1'b1;
            end
            FMT_I: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1; use_imm = 1'b1;
            end
            FMT_S, FMT_B: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1; use_imm = 1'b1;
            end
            FMT_U, FMT_J: begin
                use_rd = 1'b1; use_imm = 1'b1;
            end
            default: ;
        endcase
    end

    // Legality: only registers that the format actually uses are subject to
    // the RV32E index limit.
    always_comb begin
        bad = 1'b0;
        if (bus.instr[1:0] != 2'b11 || dec_fmt == FMT_NONE)
            bad = 1'b1;
        if (dec_fmt == FMT_R) begin
            if (!(f7 == F7_BASE || f7 == F7_ALT || (ENABLE_M && f7 == F7_MULDIV)))
                bad = 1'b1;
            if (f7 == F7_ALT && f3 != 3'b000 && f3 != 3'b101)
                bad = 1'b1;
        end
        if (ENABLE_E && ((use_rd  && bus.instr[11]) ||
                         (use_rs1 && bus.instr[19]) ||
                         (use_rs2 && bus.instr[24])))
            bad = 1'b1;
        if (opcode == OPC_JALR && f3 != 3'b000)
            bad = 1'b1;
    end

    // Illegal words keep their format but lose all valid flags and the imm.
    always_comb begin
        dec             = DECODE_RESET;
        dec.rs1         = bus.instr[19:15];
        dec.rs2         = bus.instr[24:20];
        dec.rd          = bus.instr[11:7];
        dec.func3       = f3;
        dec.func7       = f7;
        dec.imm         = bad ? 32'd0 : gen_imm;
        dec.fmt         = dec_fmt;
        dec.rd_valid    = use_rd  && !bad;
        dec.rs1_valid   = use_rs1 && !bad;
        dec.rs2_valid   = use_rs2 && !bad;
        dec.func3_valid = use_f3  && !bad;
        dec.func7_valid = use_f7  && !bad;
        dec.imm_valid   = use_imm && !bad;
        dec.is_m        = (dec_fmt == FMT_R) && (f7 == F7_MULDIV) && !bad;
        dec.illegal     = bad;
    end

    assign in_ready     = !out_valid_q || bus.out_ready;
    assign bus.in_ready = in_ready;

    // Single-entry pipeline register. Data is only written on a transfer, so
    // a stalled bundle stays bit-stable; flush and drain only clear valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pc_q        <= RESET_PC;
            held        <= DECODE_RESET;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (bus.in_valid && in_ready) begin
            out_valid_q <= 1'b1;
            pc_q        <= bus.in_pc;
            held        <= dec;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = pc_q;
    assign bus.rs1         = held.rs1;
    assign bus.rs2         = held.rs2;
    assign bus.rd          = held.rd;
    assign bus.func3       = held.func3;
    assign bus.func7       = held.func7;
    assign bus.imm         = held.imm;
    assign bus.fmt         = held.fmt;
    assign bus.rd_valid    = held.rd_valid;
    assign bus.rs1_valid   = held.rs1_valid;
    assign bus.rs2_valid   = held.rs2_valid;
    assign bus.func3_valid = held.func3_valid;
    assign bus.func7_valid = held.func7_valid;
    assign bus.imm_valid   = held.imm_valid;
    assign bus.is_m        = held.is_m;
    assign bus.illegal     = held.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: three decode stages (base, +M, RV32E) driven by the
// same stimulus and compared every cycle against a behavioural model.
module tb_rv_decode_stage;
    import rv_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        outReady;
    logic [31:0] instrIn;
    logic [31:0] pcIn;

    logic        obsValid [3];
    logic        obsReady [3];
    logic [31:0] obsPc    [3];
    decode_t     obsDec   [3];

    int      checks = 0;
    int      errors = 0;
    bit      expValid = 1'b0;
    bit      expReset = 1'b0;
    logic [31:0] expPc = RST_PC;
    decode_t expDec [3];
    int      consumedModel = 0;
    int      consumedDut = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Config 0: base RV32I, config 1: ENABLE_M, config 2: ENABLE_E.
    for (genvar k = 0; k < 3; k++) begin : g_dut
        rv_decode_stage_if #(.PC_W(32)) bus ();

        rv_decode_stage #(
            .PC_W(32), .ENABLE_E(k == 2), .ENABLE_M(k == 1), .RESET_PC(RST_PC)
        ) dut (
            .clk(clk), .rst(rst), .flush(flush), .bus(bus)
        );

        assign bus.in_valid  = inValid;
        assign bus.instr     = instrIn;
        assign bus.in_pc     = pcIn;
        assign bus.out_ready = outReady;

        assign obsValid[k] = bus.out_valid;
        assign obsReady[k] = bus.in_ready;
        assign obsPc[k]    = bus.out_pc;
        assign obsDec[k]   = '{rs1: bus.rs1, rs2: bus.rs2, rd: bus.rd,
                               func3: bus.func3, func7: bus.func7, imm: bus.imm,
                               fmt: bus.fmt, rd_valid: bus.rd_valid,
                               rs1_valid: bus.rs1_valid, rs2_valid: bus.rs2_valid,
                               func3_valid: bus.func3_valid,
                               func7_valid: bus.func7_valid,
                               imm_valid: bus.imm_valid, is_m: bus.is_m,
                               illegal: bus.illegal};
    end

    // Bundles handed downstream, counted from the DUT side.
    always @(posedge clk) begin
        if (rst === 1'b0 && obsValid[0] === 1'b1 && outReady === 1'b1)
            consumedDut++;
    end

    task automatic checkOutput(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic decode_t resetBundle();
        decode_t d;
        d = '0;
        d.fmt = 3'd7;
        return d;
    endfunction

    // Reference decode straight from the ISA rules.
    function automatic decode_t refDecode(input logic [31:0] w, input bit useE,
                                          input bit useM);
        decode_t d;
        int kind;
        int immVal;
        bit bad;
        bit uRd, uRs1, uRs2, uF3, uF7, uImm;
        d = '0;
        d.rs1   = w[19:15];
        d.rs2   = w[24:20];
        d.rd    = w[11:7];
        d.func3 = w[14:12];
        d.func7 = w[31:25];
        case (w[6:0])
            7'h33:               kind = 0;
            7'h13, 7'h03, 7'h67: kind = 1;
            7'h23:               kind = 2;
            7'h63:               kind = 3;
            7'h37, 7'h17:        kind = 4;
            7'h6F:               kind = 5;
            default:             kind = 7;
        endcase
        uRd  = kind inside {0, 1, 4, 5};
        uRs1 = kind inside {0, 1, 2, 3};
        uRs2 = kind inside {0, 2, 3};
        uF3  = kind inside {0, 1, 2, 3};
        uF7  = (kind == 0);
        uImm = kind inside {1, 2, 3, 4, 5};
        case (kind)
            1:       immVal = int'($signed(w[31:20]));
            2:       immVal = int'($signed({w[31:25], w[11:7]}));
            3:       immVal = int'($signed({w[31], w[7], w[30:25], w[11:8]})) * 2;
            4:       immVal = int'(w & 32'hFFFF_F000);
            5:       immVal = int'($signed({w[31], w[19:12], w[20], w[30:21]})) * 2;
            default: immVal = 0;
        endcase
        bad = (w[1:0] != 2'b11) || (kind == 7);
        if (kind == 0) begin
            if (!(d.func7 == 7'd0 || d.func7 == 7'd32 || (useM && d.func7 == 7'd1)))
                bad = 1'b1;
            if (d.func7 == 7'd32 && !(d.func3 == 3'd0 || d.func3 == 3'd5))
                bad = 1'b1;
        end
        if (useE && ((uRd && d.rd >= 5'd16) || (uRs1 && d.rs1 >= 5'd16) ||
                     (uRs2 && d.rs2 >= 5'd16)))
            bad = 1'b1;
        if (w[6:0] == 7'h67 && d.func3 != 3'd0)
            bad = 1'b1;
        d.fmt         = 3'(kind);
        d.imm         = bad ? 32'd0 : 32'(immVal);
        d.rd_valid    = uRd  && !bad;
        d.rs1_valid   = uRs1 && !bad;
        d.rs2_valid   = uRs2 && !bad;
        d.func3_valid = uF3  && !bad;
        d.func7_valid = uF7  && !bad;
        d.imm_valid   = uImm && !bad;
        d.is_m        = (kind == 0) && d.func7 == 7'd1 && !bad;
        d.illegal     = bad;
        return d;
    endfunction

    // Drive one cycle of inputs, check in_ready before the edge, advance the
    // model on the edge and compare every DUT on the following falling edge.
    task automatic applyStimulus(input bit r, input bit f, input bit v,
                                 input logic [31:0] w, input logic [31:0] pc,
                                 input bit ord);
        bit accept;
        rst = r; flush = f; inValid = v; instrIn = w; pcIn = pc; outReady = ord;
        #1;
        if (!r) begin
            for (int k = 0; k < 3; k++)
                checkOutput($sformatf("cfg%0d.in_ready", k), 128'(obsReady[k]),
                            128'(!expValid || ord));
        end
        @(posedge clk);
        accept = v && (!expValid || ord);
        expReset = 1'b0;
        if (!r && expValid && ord)
            consumedModel++;
        if (r) begin
            expValid = 1'b0;
            expReset = 1'b1;
            expPc    = RST_PC;
            for (int k = 0; k < 3; k++) expDec[k] = resetBundle();
        end else if (f) begin
            expValid = 1'b0;
        end else if (accept) begin
            expValid  = 1'b1;
            expPc     = pc;
            expDec[0] = refDecode(w, 1'b0, 1'b0);
            expDec[1] = refDecode(w, 1'b0, 1'b1);
            expDec[2] = refDecode(w, 1'b1, 1'b0);
        end else if (ord) begin
            expValid = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("cfg%0d.out_valid", k), 128'(obsValid[k]),
                        128'(expValid));
            if (expValid || expReset) begin
                checkOutput($sformatf("cfg%0d.out_pc", k), 128'(obsPc[k]),
                            128'(expPc));
                checkOutput($sformatf("cfg%0d.bundle", k), 128'(obsDec[k]),
                            128'(expDec[k]));
            end
        end
    endtask

    function automatic logic [31:0] randInstr();
        logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                                7'h37, 7'h17, 7'h6F};
        logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h7F};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(7) == 0)
            return w;
        w[6:0] = ops[$urandom_range(8)];
        if (w[6:0] == 7'h33)
            w[31:25] = f7s[$urandom_range(3)];
        if (w[6:0] == 7'h67 && $urandom_range(1) == 0)
            w[14:12] = 3'd0;
        if ($urandom_range(1) == 0) begin
            w[11] = 1'b0; w[19] = 1'b0; w[24] = 1'b0;
        end
        return w;
    endfunction

    initial begin
        decode_t snap;

        // Reset state.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("reset.fmt", 128'(obsDec[0].fmt), 128'(3'd7));
        checkOutput("reset.out_pc", 128'(obsPc[0]), 128'(RST_PC));

        // addi x1,x0,5
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0050_0093, 32'h200, 1'b1);
        checkOutput("addi.out_valid", 128'(obsValid[0]), 128'(1'b1));
        checkOutput("addi.fmt", 128'(obsDec[0].fmt), 128'(3'd1));
        checkOutput("addi.rd", 128'(obsDec[0].rd), 128'(5'd1));
        checkOutput("addi.rs1", 128'(obsDec[0].rs1), 128'(5'd0));
        checkOutput("addi.imm", 128'(obsDec[0].imm), 128'(32'd5));
        checkOutput("addi.rs2_valid", 128'(obsDec[0].rs2_valid), 128'(1'b0));
        checkOutput("addi.illegal", 128'(obsDec[0].illegal), 128'(1'b0));

        // beq x0,x0,-4
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFE00_0EE3, 32'h204, 1'b1);
        checkOutput("beq.fmt", 128'(obsDec[0].fmt), 128'(3'd3));
        checkOutput("beq.imm", 128'(obsDec[0].imm), 128'(32'hFFFF_FFFC));
        checkOutput("beq.rd_valid", 128'(obsDec[0].rd_valid), 128'(1'b0));

        // lui x5,0x12345
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234_52B7, 32'h208, 1'b1);
        checkOutput("lui.fmt", 128'(obsDec[0].fmt), 128'(3'd4));
        checkOutput("lui.imm", 128'(obsDec[0].imm), 128'(32'h1234_5000));
        checkOutput("lui.rd", 128'(obsDec[0].rd), 128'(5'd5));

        // mul x3,x1,x2 with and without the M extension
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0220_81B3, 32'h20C, 1'b1);
        checkOutput("mul.base.illegal", 128'(obsDec[0].illegal), 128'(1'b1));
        checkOutput("mul.base.flags",
                    128'({obsDec[0].rd_valid, obsDec[0].rs1_valid, obsDec[0].rs2_valid,
                          obsDec[0].func3_valid, obsDec[0].func7_valid,
                          obsDec[0].imm_valid}), 128'(6'd0));
        checkOutput("mul.m.is_m", 128'(obsDec[1].is_m), 128'(1'b1));
        checkOutput("mul.m.illegal", 128'(obsDec[1].illegal), 128'(1'b0));

        // RV32E register limit
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0100_0093, 32'h210, 1'b1);
        checkOutput("e.addi16.illegal", 128'(obsDec[2].illegal), 128'(1'b0));
        checkOutput("e.addi16.imm", 128'(obsDec[2].imm), 128'(32'd16));
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0893, 32'h214, 1'b1);
        checkOutput("e.rd17.illegal", 128'(obsDec[2].illegal), 128'(1'b1));
        checkOutput("base.rd17.illegal", 128'(obsDec[0].illegal), 128'(1'b0));

        // Backpressure: bundle held five cycles, next word taken on release.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0050_0093, 32'h300, 1'b1);
        snap = obsDec[0];
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234_52B7, 32'h304, 1'b0);
            checkOutput("bp.hold.bundle", 128'(obsDec[0]), 128'(snap));
            checkOutput("bp.hold.pc", 128'(obsPc[0]), 128'(32'h300));
            checkOutput("bp.in_ready", 128'(obsReady[0]), 128'(1'b0));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234_52B7, 32'h304, 1'b1);
        checkOutput("bp.release.pc", 128'(obsPc[0]), 128'(32'h304));
        checkOutput("bp.release.fmt", 128'(obsDec[0].fmt), 128'(3'd4));
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

        // Flush drops both the held bundle and the simultaneous input.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0050_0093, 32'h400, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h1234_52B7, 32'h404, 1'b0);
        checkOutput("flush.out_valid", 128'(obsValid[0]), 128'(1'b0));
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("flush.dropped", 128'(obsValid[0]), 128'(1'b0));

        // Reset while a bundle is stalled.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0050_0093, 32'h500, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_52B7, 32'h504, 1'b0);
        checkOutput("rst.out_valid", 128'(obsValid[0]), 128'(1'b0));
        checkOutput("rst.out_pc", 128'(obsPc[0]), 128'(RST_PC));

        // Random stream with backpressure, flushes and the odd reset.
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(79) == 0, $urandom_range(19) == 0,
                          $urandom_range(3) != 0, randInstr(), $urandom,
                          $urandom_range(2) != 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("stream.consumed", 128'(consumedDut), 128'(consumedModel));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
